// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and per-frame result strobes of the UART receiver
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
    logic                  RX_IN;
    logic [5:0]            PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    modport master (output RX_IN, PRESCALE, PAR_EN, PAR_TYP, input P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
    modport slave (input RX_IN, PRESCALE, PAR_EN, PAR_TYP, output P_DATA, DATA_VALID, PAR_ERR, STP_ERR);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 2-of-3 majority sampling, parity and stop checks
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic      CLK,
    input logic      RST_n,
    uart_rx_if.slave bus
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state, nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                  rx_s, s0, s1, maj, last, mid, done, armed;
    logic [5:0]            pre_q, edge_cnt, half;
    logic [BW-1:0]         bit_cnt;
    logic                  par_en_q, par_typ_q, par_fail, stp_fail;
    logic [DATA_WIDTH-1:0] shift, p_data;
    logic                  data_valid, par_err, stp_err;
    assign rx_s = sync[SYNC_STAGES-1];
    assign half = {1'b0, pre_q[5:1]};
    assign last = edge_cnt == pre_q - 6'd1;
    assign mid  = edge_cnt == half + 6'd1;
    assign maj  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign done = state == STOP && last;
    assign bus.P_DATA     = p_data;
    assign bus.DATA_VALID = data_valid;
    assign bus.PAR_ERR    = par_err;
    assign bus.STP_ERR    = stp_err;
    always_ff @(posedge CLK or negedge RST_n)
        if (!RST_n) state <= IDLE;
        else        state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (!rx_s && armed) ? START : IDLE;
            START:   nxt = (mid && maj) ? IDLE : last ? DATA : START;
            DATA:    nxt = (last && bit_cnt == BW'(DATA_WIDTH - 1)) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  nxt = last ? STOP : PARITY;
            STOP:    nxt = last ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end
    // armed drops after a stop failure so a line held low cannot re-trigger until it returns high
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync       <= '1;
            pre_q      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            s0         <= 1'b1;
            s1         <= 1'b1;
            shift      <= '0;
            par_fail   <= 1'b0;
            stp_fail   <= 1'b0;
            armed      <= 1'b1;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.RX_IN};
            if (state == IDLE) begin
                pre_q     <= bus.PRESCALE;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
            end
            edge_cnt <= (state == IDLE || nxt == IDLE || last) ? '0 : edge_cnt + 6'd1;
            bit_cnt  <= state != DATA ? '0 : last ? bit_cnt + BW'(1) : bit_cnt;
            s0       <= edge_cnt == half - 6'd1 ? rx_s : s0;
            s1       <= edge_cnt == half ? rx_s : s1;
            if (state == DATA && mid)
                shift[bit_cnt] <= maj;
            par_fail <= state == START ? 1'b0 : (state == PARITY && mid) ? maj != (^shift ^ par_typ_q) : par_fail;
            stp_fail <= state == START ? 1'b0 : (state == STOP && mid) ? !maj : stp_fail;
            armed    <= rx_s | (armed & !(done & stp_fail));
            if (done && !stp_fail && !par_fail)
                p_data <= shift;
            data_valid <= done & !stp_fail & !par_fail;
            par_err    <= done & !stp_fail & par_fail;
            stp_err    <= done & stp_fail;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: random and directed UART frames checked against a frame-level outcome model
module tb_uart_rx;
    localparam int SYNC = 2;
    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    uart_rx_if #(.DATA_WIDTH(8)) bus ();
    uart_rx #(.DATA_WIDTH(8), .SYNC_STAGES(SYNC)) dut (.CLK(CLK), .RST_n(RST_n), .bus(bus));
    always #5 CLK = ~CLK;
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;
    ev_t        obs[$];
    ev_t        expq[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         t_fall = 0;
    int         first_cyc = -1;
    logic [7:0] last_good = 8'h00;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin : mon
        ev_t e;
        if (RST_n && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            e.kind = {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR};
            e.data = bus.P_DATA;
            e.cyc  = cyc;
            obs.push_back(e);
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask
    task automatic send_frame(input logic [7:0] d, input int ps, input bit pen, input bit ptyp,
                              input bit bad_par, input bit stop_bit, input int gbit, input int gap,
                              input int cut, input bit scramble);
        logic [10:0] bits;
        int          n;
        ev_t         e;
        bus.PRESCALE = 6'(ps);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        n    = pen ? 11 : 10;
        bits = pen ? {stop_bit, ^d ^ ptyp ^ bad_par, d, 1'b0} : {1'b0, stop_bit, d, 1'b0};
        t_fall = cyc;
        for (int i = 0; i < (cut > 0 ? cut : n); i++)
            for (int t = 0; t < ps; t++) begin
                bus.RX_IN = (i == gbit && t == ps / 2) ? ~bits[i] : bits[i];
                if (scramble && i == 1 && t == 0) begin
                    bus.PAR_EN   = 1'($urandom);
                    bus.PAR_TYP  = 1'($urandom);
                    bus.PRESCALE = 6'(8 << $urandom_range(0, 2));
                end
                tick(1);
            end
        if (cut == 0) begin
            e.cyc = 0;
            if (!stop_bit) e.kind = 3'b001;
            else if (pen && bad_par) e.kind = 3'b010;
            else begin
                e.kind    = 3'b100;
                last_good = d;
            end
            e.data = last_good;
            expq.push_back(e);
            if (gap > 0) begin
                bus.RX_IN = 1'b1;
                tick(gap);
            end
        end
    endtask
    task automatic settle();
        int k = 0;
        while (obs.size() < expq.size() && k < 600) begin
            tick(1);
            k++;
        end
        tick(10);
        chk("event_count", obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            chk("strobe_kind", obs[i].kind, expq[i].kind);
            chk("p_data", obs[i].data, expq[i].data);
        end
        first_cyc = obs.size() > 0 ? obs[0].cyc : -1;
        obs.delete();
        expq.delete();
    endtask
    task automatic chk_lat(input int frame_bits, input int ps);
        int lat, e;
        lat = first_cyc - t_fall;
        e   = SYNC + 1 + frame_bits * ps;
        chk($sformatf("latency_%0d", lat), 32'(lat >= e - 1 && lat <= e + 1), 32'd1);
    endtask
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = 6'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        tick(3);
        chk("rst_p_data", bus.P_DATA, 0);
        chk("rst_valid", bus.DATA_VALID, 0);
        chk("rst_par_err", bus.PAR_ERR, 0);
        chk("rst_stp_err", bus.STP_ERR, 0);
        RST_n = 1'b1;
        tick(5);
        send_frame(8'hA5, 8, 0, 0, 0, 1, -1, 16, 0, 0);
        settle();
        chk_lat(10, 8);
        send_frame(8'h3C, 16, 1, 1, 0, 1, -1, 32, 0, 0);
        settle();
        chk_lat(11, 16);
        send_frame(8'h3C, 16, 1, 1, 1, 1, -1, 32, 0, 0);
        settle();
        send_frame(8'h81, 32, 1, 0, 0, 0, -1, 64, 0, 0);
        send_frame(8'h7E, 32, 1, 0, 0, 1, -1, 64, 0, 0);
        settle();
        bus.PRESCALE = 6'd16;
        bus.RX_IN    = 1'b0;
        tick(3);
        bus.RX_IN = 1'b1;
        tick(40);
        settle();
        send_frame(8'h55, 16, 0, 0, 0, 1, -1, 32, 0, 0);
        settle();
        send_frame(8'hFF, 16, 0, 0, 0, 1, 4, 32, 0, 0);
        settle();
        send_frame(8'h00, 16, 0, 0, 0, 0, -1, 0, 0, 0);
        bus.RX_IN = 1'b0;
        tick(64);
        bus.RX_IN = 1'b1;
        tick(32);
        settle();
        send_frame(8'h5A, 16, 0, 0, 0, 1, -1, 32, 0, 0);
        settle();
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < 6; f++) begin
                int ps;
                ps = 8 << $urandom_range(0, 2);
                send_frame(8'($urandom), ps, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                           $urandom_range(0, 5) != 0, $urandom_range(0, 1) ? $urandom_range(1, 8) : -1,
                           $urandom_range(1, 2 * ps), 0, 1);
            end
            settle();
        end
        send_frame(8'h01, 16, 0, 0, 0, 1, -1, 0, 0, 0);
        send_frame(8'h02, 16, 0, 0, 0, 1, -1, 0, 0, 0);
        send_frame(8'h03, 16, 0, 0, 0, 1, -1, 0, 0, 0);
        send_frame(8'h04, 16, 0, 0, 0, 1, -1, 0, 5, 0);
        #3;
        RST_n = 1'b0;
        #1;
        chk("async_rst_p_data", bus.P_DATA, 0);
        bus.RX_IN = 1'b1;
        last_good = 8'h00;
        tick(3);
        RST_n = 1'b1;
        tick(5);
        settle();
        chk("post_rst_p_data", bus.P_DATA, last_good);
        send_frame(8'hC3, 8, 1, 0, 0, 1, -1, 16, 0, 0);
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
